pad_bus_ctrl: RTL and testbench

//  Half-duplex controller for a WIDTH-bit group of bidirectional I/O pad cells.

---
 rtl/pad_ctrl_pkg.sv | 26 ++
 rtl/pad_sync.sv | 26 ++
 rtl/pad_bus_ctrl.sv | 118 +++++++++++
 tb/tb_pad_bus_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pad_ctrl_pkg.sv
// Shared types, requester indices and round-robin helper for the pad bus controller.
package pad_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TA_OUT,
    DRIVE,
    TA_IN,
    SAMPLE
  } state_t;

  localparam logic [1:0] REQ_WR0 = 2'd0;
  localparam logic [1:0] REQ_WR1 = 2'd1;
  localparam logic [1:0] REQ_RD  = 2'd2;

  // First requester after 'last' in the cyclic order wr0 -> wr1 -> rd.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 3; i >= 1; i--) begin
      idx = 2'((int'(last) + i) % 3);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/pad_sync.sv
// Multi-stage flop synchronizer for the asynchronous pad Y inputs.
module pad_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  // NOTE: the stage array is a chain of flops, not a RAM, so every entry is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/pad_bus_ctrl.sv
// Half-duplex pad group controller: round-robin arbiter, turnaround FSM, registered pad outputs.
module pad_bus_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int TA_CYCLES    = 2,
  parameter int DRIVE_CYCLES = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req0,
  input  logic [WIDTH-1:0] wr_data0,
  output logic             wr_gnt0,
  input  logic             wr_req1,
  input  logic [WIDTH-1:0] wr_data1,
  output logic             wr_gnt1,
  input  logic             rd_req,
  output logic             rd_gnt,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] pad_a,
  output logic             pad_en_n,
  input  logic [WIDTH-1:0] pad_y,
  output logic             busy
);

  localparam int MAX_TD = (TA_CYCLES > DRIVE_CYCLES) ? TA_CYCLES : DRIVE_CYCLES;
  localparam int MAX_C  = (MAX_TD > SYNC_STAGES) ? MAX_TD : SYNC_STAGES;
  localparam int CW     = $clog2(MAX_C) + 1;

  state_t          state, next_state;
  logic [CW-1:0]   cnt, cnt_next;
  logic [1:0]      ptr, winner;
  logic [2:0]      req;
  logic            arb, rd_done;
  logic [WIDTH-1:0] sync_y;

  pad_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad_y),
    .q   (sync_y)
  );

  assign req    = {rd_req, wr_req1, wr_req0};
  assign winner = rr_pick(ptr, req);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    next_state = state;
    cnt_next   = (cnt == '0) ? '0 : cnt - 1'b1;
    arb        = 1'b0;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          arb = 1'b1;
          if (winner == REQ_RD) begin
            next_state = SAMPLE;
            cnt_next   = CW'(SYNC_STAGES - 1);
          end else begin
            next_state = TA_OUT;
            cnt_next   = CW'(TA_CYCLES - 1);
          end
        end
      end
      TA_OUT: if (cnt == '0) begin
        next_state = DRIVE;
        cnt_next   = CW'(DRIVE_CYCLES - 1);
      end
      DRIVE: if (cnt == '0) begin
        next_state = TA_IN;
        cnt_next   = CW'(TA_CYCLES - 1);
      end
      TA_IN: if (cnt == '0) next_state = IDLE;
      SAMPLE: if (cnt == '0) begin
        next_state = IDLE;
        rd_done    = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so pad_en_n is glitch-free at the pins.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= REQ_RD;
      wr_gnt0  <= 1'b0;
      wr_gnt1  <= 1'b0;
      rd_gnt   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      pad_a    <= '0;
      pad_en_n <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= cnt_next;
      wr_gnt0  <= arb && (winner == REQ_WR0);
      wr_gnt1  <= arb && (winner == REQ_WR1);
      rd_gnt   <= arb && (winner == REQ_RD);
      rd_valid <= rd_done;
      pad_en_n <= (next_state != DRIVE);
      busy     <= (next_state != IDLE);
      if (rd_done) rd_data <= sync_y;
      if (arb) begin
        ptr <= winner;
        if (winner == REQ_WR0) pad_a <= wr_data0;
        else if (winner == REQ_WR1) pad_a <= wr_data1;
      end
    end
  end

endmodule

// File: tb/tb_pad_bus_ctrl.sv
// Scoreboard bench for pad_bus_ctrl: stimulus pushes expected grants/reads, a monitor pops them.
module tb_pad_bus_ctrl;

  localparam int W = 8;
  localparam int EV_GNT0 = 0, EV_GNT1 = 1, EV_RGNT = 2, EV_RVALID = 3;

  typedef struct {
    int        kind;
    logic [7:0] data;
    int        cyc;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_req0 = 1'b0, wr_req1 = 1'b0, rd_req = 1'b0;
  logic [W-1:0] wr_data0 = '0, wr_data1 = '0, pad_y = '0;
  logic         wr_gnt0, wr_gnt1, rd_gnt, rd_valid, pad_en_n, busy;
  logic [W-1:0] rd_data, pad_a;

  ev_t sb[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  pad_bus_ctrl #(.WIDTH(W), .TA_CYCLES(2), .DRIVE_CYCLES(3), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_req0  (wr_req0),
    .wr_data0 (wr_data0),
    .wr_gnt0  (wr_gnt0),
    .wr_req1  (wr_req1),
    .wr_data1 (wr_data1),
    .wr_gnt1  (wr_gnt1),
    .rd_req   (rd_req),
    .rd_gnt   (rd_gnt),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .pad_a    (pad_a),
    .pad_en_n (pad_en_n),
    .pad_y    (pad_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [7:0] data, input int c);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: each DUT event pops the oldest expectation and compares kind, cycle and data.
  task automatic observe(input int kind, input logic [7:0] data);
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL spurious_event @cyc %0d: got kind %0d with nothing expected", cyc, kind);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (kind != EV_RGNT) check("event_data", {24'd0, data}, {24'd0, e.data});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_gnt0)  observe(EV_GNT0, pad_a);
      if (wr_gnt1)  observe(EV_GNT1, pad_a);
      if (rd_gnt)   observe(EV_RGNT, 8'h00);
      if (rd_valid) observe(EV_RVALID, rd_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    check("rst_pad_en_n", {31'd0, pad_en_n}, 32'd1);
    check("rst_pad_a",    {24'd0, pad_a}, 32'h0);
    check("rst_grants",   {29'd0, wr_gnt0, wr_gnt1, rd_gnt}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data",  {24'd0, rd_data}, 32'h0);
    check("rst_busy",     {31'd0, busy}, 32'd0);

    // 1: single write from wr0
    wr_data0 = 8'hA5;
    wr_req0  = 1'b1;
    g = cyc + 1;
    push(EV_GNT0, 8'hA5, g);
    tick();
    wr_req0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("w1_pad_en_n", {31'd0, pad_en_n}, (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
      check("w1_busy",     {31'd0, busy}, (k < 7) ? 32'd1 : 32'd0);
      check("w1_pad_a",    {24'd0, pad_a}, 32'hA5);
      tick();
    end

    // 2: single read
    pad_y  = 8'h3C;
    repeat (3) tick();
    rd_req = 1'b1;
    g = cyc + 1;
    push(EV_RGNT, 8'h00, g);
    push(EV_RVALID, 8'h3C, g + 2);
    tick();
    rd_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("r2_pad_en_n", {31'd0, pad_en_n}, 32'd1);
      check("r2_rd_valid", {31'd0, rd_valid}, (k == 2) ? 32'd1 : 32'd0);
      if (k == 2) check("r2_rd_data", {24'd0, rd_data}, 32'h3C);
      tick();
    end
    wait_idle();

    // 3: all requests held after reset -> wr0, wr1, rd, wr0 with one idle cycle between
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_data0 = 8'h5A;
    wr_data1 = 8'hC3;
    pad_y    = 8'h96;
    wr_req0 = 1'b1;
    wr_req1 = 1'b1;
    rd_req  = 1'b1;
    g = cyc + 1;
    push(EV_GNT0,   8'h5A, g);
    push(EV_GNT1,   8'hC3, g + 8);
    push(EV_RGNT,   8'h00, g + 16);
    push(EV_RVALID, 8'h96, g + 18);
    push(EV_GNT0,   8'h5A, g + 19);
    while (cyc < g + 19) tick();
    wr_req0 = 1'b0;
    wr_req1 = 1'b0;
    rd_req  = 1'b0;
    wait_idle();
    tick();

    // 4: reset in the second DRIVE cycle aborts the write; held wr1 is granted again
    wr_data1 = 8'h77;
    wr_req1  = 1'b1;
    g = cyc + 1;
    push(EV_GNT1, 8'h77, g);
    while (cyc < g + 3) tick();
    check("r4_driving", {31'd0, pad_en_n}, 32'd0);
    rst = 1'b1;
    tick();
    check("r4_pad_en_n", {31'd0, pad_en_n}, 32'd1);
    check("r4_busy",     {31'd0, busy}, 32'd0);
    check("r4_pad_a",    {24'd0, pad_a}, 32'h0);
    rst = 1'b0;
    push(EV_GNT1, 8'h77, cyc + 1);
    tick();
    wr_req1 = 1'b0;
    wait_idle();
    tick();

    // 5+6: wr1 data changes after grant; wr0 pulses once while busy
    wr_data1 = 8'h11;
    wr_req1  = 1'b1;
    g = cyc + 1;
    push(EV_GNT1, 8'h11, g);
    tick();
    wr_req1  = 1'b0;
    wr_data1 = 8'h22;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) wr_req0 = 1'b1;
      if (k == 4) wr_req0 = 1'b0;
      check("w5_pad_a",    {24'd0, pad_a}, 32'h11);
      check("w5_pad_en_n", {31'd0, pad_en_n}, (k >= 2 && k <= 4) ? 32'd1 - 32'd1 : 32'd1);
      tick();
    end
    repeat (5) tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
